pipe_stage_chain: RTL and testbench
===================================

// Module: pipe_stage_chain
// PURPOSE
//  Parametrised chain of pipeline stage registers with per-stage valid/allowin/ready_go handshake,
//  stall back-pressure and per-stage flush. Successor to hand-wired IF/ID/EX/MEM/WB latches in mycpu_top:
//  each CPU stage boundary instantiates one chain (or one chain spans several boundaries).
//  Carries an opaque DW-bit payload (PC, IR, control bundle) and never inspects it.
// PARAMETERS
//  STAGES  4   number of register stages (>=1)
//  DW      32  payload width per stage, bits
//  CW      3   occupancy counter width; must be >= $clog2(STAGES+1)
// PORTS
//  clk          in   1          rising-edge clock
//  resetn       in   1          asynchronous, active-low reset
//  in_valid     in   1          upstream offers payload
//  in_allowin   out  1          chain accepts payload this cycle (= allowin of stage 0)
//  in_data      in   DW         upstream payload
//  ready_go     in   STAGES     bit i: stage i finished its work, may hand payload on
//  flush        in   STAGES     bit i: kill content of stage i (branch/exception redirect)
//  out_valid    out  1          last stage offers payload downstream
//  out_allowin  in   1          downstream accepts
//  out_data     out  DW         payload of last stage
//  stage_valid  out  STAGES     valid bit of every stage
//  stage_data   out  STAGES*DW  payload of every stage, stage i at [i*DW +: DW]
//  occupancy    out  CW         registered count of valid stages
// BEHAVIOUR
//  - Reset (resetn=0, async): all valid_i=0, all data_i=0, occupancy=0; hence out_valid=0,
//    in_allowin=1. Reset mid-transfer discards all in-flight payloads; nothing is emitted.
//  - Combinational per stage i (0..STAGES-1), allowin_STAGES = out_allowin:
//      go_i      = valid_i & ready_go[i] & ~flush[i]
//      allowin_i = ~valid_i | (ready_go[i] & allowin_{i+1}) | flush[i]
//    input of stage 0 is in_valid; input of stage i>0 is go_{i-1}.
//  - Clock edge, stage i: if flush[i]: valid_i<=0 (any incoming payload dropped, never re-offered);
//    else if allowin_i: valid_i<=input_valid_i, data_i<=input_data_i when input_valid_i (else held).
//    else hold. Flush has priority over load; flush of stage i does not affect stages != i.
//  - out_valid = go_{STAGES-1}; out_data = data_{STAGES-1}. Transfer out when out_valid & out_allowin.
//  - Upstream handshake: transfer in when in_valid & in_allowin; in_data sampled on that edge only.
//  - Latency: with ready_go all 1, out_allowin=1, payload accepted on edge t is out_valid in the
//    cycle following edge t+STAGES-1 (STAGES cycles); throughput 1 payload/cycle, no bubbles.
//  - Stall: ready_go[i]=0 holds stage i; back-pressure ripples to stage 0 only through full stages;
//    empty stages upstream of a stall keep filling (bubble collapse).
//  - Full: all valid, out_allowin=0 -> in_allowin=0, all data stable. Simultaneous in and out
//    transfer when full is legal (shift by one).
//  - occupancy <= popcount of next-state valid vector; range 0..STAGES, never wraps.
//  - No payload is ever duplicated or reordered; flushed payloads vanish silently.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined: adds outputs perf_retired[31:0] (++ on each out transfer) and
//    perf_bubble[31:0] (++ each cycle out_allowin=1 & out_valid=0); both reset to 0 by resetn,
//    wrap 0xFFFFFFFF->0. Not defined: ports and counters absent, behaviour otherwise identical.
// TESTING (STAGES=4, DW=32)
//  - Reset: resetn=0 mid-stream with 3 valid stages -> next cycle stage_valid=4'b0000, occupancy=0,
//    out_valid=0, in_allowin=1 asynchronously; no out transfer after release.
//  - Streaming: feed 0x100,0x104,0x108 on consecutive edges, ready_go=4'hF, out_allowin=1 ->
//    out_data 0x100,0x104,0x108 on cycles 4,5,6 with out_valid=1; occupancy peaks at 3.
//  - Stall: fill 4 items 0xA0..0xA3, out_allowin=0 -> in_allowin=0, occupancy=4, data stable;
//    release -> 0xA0..0xA3 emitted in order on consecutive cycles.
//  - Bubble collapse: ready_go[2]=0 for 3 cycles with stages 0,2 valid -> stage 0 payload advances
//    to stage 1, in_allowin stays 1 until stages 0..2 full.
//  - Flush: stages 1,2 hold 0xB1,0xB2, flush=4'b0110 for one cycle while stage 0 offers 0xB0 ->
//    0xB1,0xB2 never appear at out_data, 0xB0 dropped (not in stage 1), stage 3 content unaffected.
//  - PIPE_PERF_CNT_EN: stream 10 items, 2 idle cycles with out_allowin=1 -> perf_retired=10,
//    perf_bubble counts all empty-output cycles incl. 3 fill cycles (=5).

Source files
------------

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain
//   Chain of STAGES pipeline registers with a per-stage valid/allowin/ready_go
//   handshake. The chain supports stall back-pressure and a flush for each stage.
//   The DW-bit payload is opaque and is only ever moved, never inspected.
//
//   Optional feature: define PIPE_PERF_CNT_EN to add the perf_retired and
//   perf_bubble counters.
//
// Ports
//   clk          rising-edge clock
//   resetn       asynchronous active-low reset
//   in_valid     upstream offers in_data
//   in_allowin   stage 0 accepts this cycle
//   in_data      upstream payload
//   ready_go     bit i: stage i may hand its payload on
//   flush        bit i: kill the content of stage i
//   out_valid    last stage offers out_data downstream
//   out_allowin  downstream accepts
//   out_data     payload of the last stage
//   stage_valid  valid bit of every stage
//   stage_data   payload of every stage; stage i is at [i*DW +: DW]
//   occupancy    registered count of valid stages
//   perf_retired (PIPE_PERF_CNT_EN) number of out transfers, wraps
//   perf_bubble  (PIPE_PERF_CNT_EN) cycles with out_allowin & ~out_valid, wraps
module pipe_stage_chain #(
  parameter int unsigned STAGES = 4,
  parameter int unsigned DW     = 32,
  parameter int unsigned CW     = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_allowin,
  input  logic [DW-1:0]        in_data,
  input  logic [STAGES-1:0]    ready_go,
  input  logic [STAGES-1:0]    flush,
  output logic                 out_valid,
  input  logic                 out_allowin,
  output logic [DW-1:0]        out_data,
  output logic [STAGES-1:0]    stage_valid,
  output logic [STAGES*DW-1:0] stage_data,
  output logic [CW-1:0]        occupancy
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]          perf_retired,
  output logic [31:0]          perf_bubble
`endif
);

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] go;
  logic [STAGES-1:0] load_valid;
  logic [STAGES:0]   allowin;
  logic [DW-1:0]     data_q    [STAGES];
  logic [DW-1:0]     load_data [STAGES];
  logic [CW-1:0]     occ_d;

  // allowin ripples from the output end back to stage 0. The loop walks
  // downward so that each bit is computed from the already-computed bit above it.
  always_comb begin
    allowin         = '0;
    allowin[STAGES] = out_allowin;
    for (int unsigned k = 0; k < STAGES; k++) begin
      allowin[STAGES-1-k] = ~valid_q[STAGES-1-k]
                          | (ready_go[STAGES-1-k] & allowin[STAGES-k])
                          | flush[STAGES-1-k];
    end
  end

  always_comb begin
    go = valid_q & ready_go & ~flush;
  end

  // What each stage would load: stage 0 loads from upstream, and every
  // later stage loads from its predecessor.
  always_comb begin
    load_valid    = '0;
    load_valid[0] = in_valid;
    load_data[0]  = in_data;
    for (int unsigned k = 1; k < STAGES; k++) begin
      load_valid[k] = go[k-1];
      load_data[k]  = data_q[k-1];
    end
  end

  // Flush beats load. A payload that is handed into a flushed stage is lost.
  always_comb begin
    valid_d = valid_q;
    occ_d   = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (flush[k]) begin
        valid_d[k] = 1'b0;
      end else if (allowin[k]) begin
        valid_d[k] = load_valid[k];
      end
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      occ_d = occ_d + CW'(valid_d[k]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q   <= '0;
      occupancy <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      occupancy <= occ_d;
      for (int unsigned k = 0; k < STAGES; k++) begin
        // Data only moves on a real load; an empty load keeps the old bits.
        if (!flush[k] && allowin[k] && load_valid[k]) begin
          data_q[k] <= load_data[k];
        end
      end
    end
  end

  always_comb begin
    in_allowin  = allowin[0];
    out_valid   = go[STAGES-1];
    out_data    = data_q[STAGES-1];
    stage_valid = valid_q;
    stage_data  = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      stage_data[k*DW +: DW] = data_q[k];
    end
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_retired <= '0;
      perf_bubble  <= '0;
    end else begin
      if (out_valid && out_allowin) begin
        perf_retired <= perf_retired + 32'd1;
      end
      if (out_allowin && !out_valid) begin
        perf_bubble <= perf_bubble + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain
//   Directed bench for pipe_stage_chain with STAGES=4 and DW=32. Inputs change
//   on the falling edge, and outputs are checked there as well.
module tb_pipe_stage_chain;

  localparam int unsigned STAGES = 4;
  localparam int unsigned DW     = 32;
  localparam int unsigned CW     = 3;

  localparam logic        STREAM_OV  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam logic [31:0] STREAM_OD  [7] = '{32'h0, 32'h0, 32'h0, 32'h100, 32'h104, 32'h108, 32'h0};
  localparam logic [2:0]  STREAM_OCC [7] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0};

  logic                 clk = 1'b0;
  logic                 resetn;
  logic                 in_valid;
  logic                 in_allowin;
  logic [DW-1:0]        in_data;
  logic [STAGES-1:0]    ready_go;
  logic [STAGES-1:0]    flush;
  logic                 out_valid;
  logic                 out_allowin;
  logic [DW-1:0]        out_data;
  logic [STAGES-1:0]    stage_valid;
  logic [STAGES*DW-1:0] stage_data;
  logic [CW-1:0]        occupancy;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0]          perf_retired;
  logic [31:0]          perf_bubble;
  logic [31:0]          bubble_snap;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  pipe_stage_chain #(
    .STAGES (STAGES),
    .DW     (DW),
    .CW     (CW)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_allowin  (in_allowin),
    .in_data     (in_data),
    .ready_go    (ready_go),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_allowin (out_allowin),
    .out_data    (out_data),
    .stage_valid (stage_valid),
    .stage_data  (stage_data),
    .occupancy   (occupancy)
`ifdef PIPE_PERF_CNT_EN
    ,
    .perf_retired(perf_retired),
    .perf_bubble (perf_bubble)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one beat, then move to the next falling edge.
  task automatic feed(input logic v, input logic [31:0] d);
    in_valid = v;
    in_data  = d;
    @(negedge clk);
  endtask

  initial begin
    resetn      = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    ready_go    = '1;
    flush       = '0;
    out_allowin = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_valid", stage_valid, 4'b0000);
    check("rst_occ", occupancy, 3'd0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_allowin", in_allowin, 1'b1);
    check("rst_data", stage_data, 128'h0);
    resetn = 1'b1;

    // Streaming: three beats, each with a four-cycle latency
    for (int k = 0; k < 7; k++) begin
      in_valid = (k < 3);
      in_data  = 32'h100 + 32'(4 * k);
      @(negedge clk);
      check($sformatf("stream_ov%0d", k), out_valid, STREAM_OV[k]);
      check($sformatf("stream_occ%0d", k), occupancy, STREAM_OCC[k]);
      if (STREAM_OV[k]) check($sformatf("stream_od%0d", k), out_data, STREAM_OD[k]);
    end

    // Stall: fill the chain while downstream is blocked
    out_allowin = 1'b0;
    for (int j = 0; j < 4; j++) feed(1'b1, 32'hA0 + 32'(j));
    in_valid = 1'b1;
    in_data  = 32'hEE;
    #1;
    check("full_in_allowin", in_allowin, 1'b0);
    check("full_occ", occupancy, 3'd4);
    check("full_data", stage_data, 128'h000000A0_000000A1_000000A2_000000A3);
    check("full_out_valid", out_valid, 1'b1);
    check("full_out_data", out_data, 32'hA0);
    @(negedge clk);
    check("full_hold_data", stage_data, 128'h000000A0_000000A1_000000A2_000000A3);
    check("full_hold_occ", occupancy, 3'd4);
    in_valid    = 1'b0;
    out_allowin = 1'b1;
    #1;
    check("full_shift_allowin", in_allowin, 1'b1);
    for (int j = 1; j < 4; j++) begin
      @(negedge clk);
      check($sformatf("drain_ov%0d", j), out_valid, 1'b1);
      check($sformatf("drain_od%0d", j), out_data, 32'hA0 + 32'(j));
    end
    @(negedge clk);
    check("drain_empty_ov", out_valid, 1'b0);
    check("drain_empty_occ", occupancy, 3'd0);

    // Bubble collapse: stage 2 stalls while stages 0 and 2 hold payloads
    feed(1'b1, 32'hC0);
    feed(1'b0, 32'h0);
    feed(1'b1, 32'hC1);
    in_valid = 1'b0;
    ready_go = 4'b1011;
    #1;
    check("bub_valid0", stage_valid, 4'b0101);
    check("bub_allow0", in_allowin, 1'b1);
    @(negedge clk);
    check("bub_valid1", stage_valid, 4'b0110);
    check("bub_s1", stage_data[63:32], 32'hC1);
    check("bub_allow1", in_allowin, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'hC2;
    @(negedge clk);
    check("bub_valid2", stage_valid, 4'b0111);
    check("bub_allow2", in_allowin, 1'b0);
    in_data = 32'hC3;
    @(negedge clk);
    check("bub_valid3", stage_valid, 4'b0111);
    check("bub_s0", stage_data[31:0], 32'hC2);
    in_valid = 1'b0;
    ready_go = '1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check($sformatf("bub_ov%0d", j), out_valid, 1'b1);
      check($sformatf("bub_od%0d", j), out_data, 32'hC0 + 32'(j));
    end
    @(negedge clk);
    check("bub_empty", out_valid, 1'b0);

    // Flush stages 1 and 2 of a full chain
    out_allowin = 1'b0;
    feed(1'b1, 32'hB3);
    feed(1'b1, 32'hB2);
    feed(1'b1, 32'hB1);
    feed(1'b1, 32'hB0);
    in_valid = 1'b0;
    check("fl_pre_data", stage_data, 128'h000000B3_000000B2_000000B1_000000B0);
    flush = 4'b0110;
    @(negedge clk);
    flush = '0;
    check("fl_valid", stage_valid, 4'b1000);
    check("fl_occ", occupancy, 3'd1);
    check("fl_out_valid", out_valid, 1'b1);
    check("fl_out_data", out_data, 32'hB3);
    out_allowin = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      check($sformatf("fl_after_ov%0d", j), out_valid, 1'b0);
      check($sformatf("fl_after_valid%0d", j), stage_valid, 4'b0000);
      @(negedge clk);
    end

    // Asynchronous reset with three valid stages
    feed(1'b1, 32'hD0);
    feed(1'b1, 32'hD1);
    feed(1'b1, 32'hD2);
    in_valid = 1'b0;
    check("mid_valid", stage_valid, 4'b0111);
    check("mid_occ", occupancy, 3'd3);
    resetn = 1'b0;
    #1;
    check("arst_valid", stage_valid, 4'b0000);
    check("arst_occ", occupancy, 3'd0);
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_in_allowin", in_allowin, 1'b1);
    @(negedge clk);
    resetn = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check($sformatf("arst_after_ov%0d", j), out_valid, 1'b0);
    end

`ifdef PIPE_PERF_CNT_EN
    // Performance counters: ten beats, then two idle cycles
    resetn = 1'b0;
    #1;
    check("perf_rst_ret", perf_retired, 32'd0);
    check("perf_rst_bub", perf_bubble, 32'd0);
    @(negedge clk);
    resetn      = 1'b1;
    out_allowin = 1'b1;
    bubble_snap = '0;
    for (int c = 0; c < 16; c++) begin
      in_valid = (c < 10);
      in_data  = 32'h200 + 32'(c);
      @(negedge clk);
      if (c == 0) bubble_snap = perf_bubble;
    end
    check("perf_retired", perf_retired, 32'd10);
    check("perf_bubble", perf_bubble - bubble_snap, 32'd5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
